// File: rtl/axi_isolate_seq_pkg.sv
// -----------------------------------------------------------------------------
// axi_isolate_seq_pkg
// Shared types for the AXI isolation sequencer:
//   cmd_e   - 2-bit software command encoding (Connect / Isolate / Reset / illegal)
//   state_e - 3-bit sequencer state, exported unchanged on state_o
//   max3    - helper used to size the shared down-counter
// -----------------------------------------------------------------------------
package axi_isolate_seq_pkg;

  typedef enum logic [1:0] {
    CMD_CONNECT = 2'd0,
    CMD_ISOLATE = 2'd1,
    CMD_RESET   = 2'd2,
    CMD_ILLEGAL = 2'd3
  } cmd_e;

  // Encodings visible to software through state_o.
  typedef enum logic [2:0] {
    ST_CONNECTED = 3'd0,
    ST_DRAINING  = 3'd1,
    ST_ISOLATED  = 3'd2,
    ST_RESET     = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_RELEASING = 3'd5
  } state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/axi_isolate_seq.sv
// -----------------------------------------------------------------------------
// axi_isolate_seq
// Sequences one AXI isolation stage and the reset of the domain behind it.
// Commands (connect / isolate / reset domain) arrive on a valid/ready port; the
// sequencer then runs drain -> isolate -> reset pulse -> settle -> reconnect as
// needed and signals completion with a one-cycle done_o (plus error_o for an
// illegal command or a drain timeout).
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cmd_valid_i/ready_o  command handshake; cmd_i carries a cmd_e
//   done_o, error_o      completion / error pulses (error coincides with done)
//   isolate_o            isolate request to the isolation stage
//   isolated_i           isolated status from the isolation stage
//   domain_rst_no        active-low reset to the downstream domain
//   state_o              current state_e for status registers
//
// Optional feature: define AXI_ISOLATE_SEQ_TIMEOUT_EN to bound the drain wait
// by TimeoutCycles; on expiry the port is reconnected and error_o reported.
// -----------------------------------------------------------------------------
module axi_isolate_seq
  import axi_isolate_seq_pkg::*;
#(
  parameter int unsigned ResetCycles   = 8,
  parameter int unsigned SettleCycles  = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  output logic       done_o,
  output logic       error_o,
  output logic       isolate_o,
  input  logic       isolated_i,
  output logic       domain_rst_no,
  output logic [2:0] state_o
);

  // One down-counter is shared by Reset, Settle and the drain watchdog.
  localparam int unsigned CntMax      = max3(ResetCycles, SettleCycles, TimeoutCycles);
  localparam int unsigned CntW        = $clog2(CntMax + 1);
  localparam int unsigned SettleLoadI = (SettleCycles == 0) ? 0 : SettleCycles - 1;
  localparam logic [CntW-1:0] ResetLoad  = CntW'(ResetCycles - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SettleLoadI);
`ifdef AXI_ISOLATE_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles - 1);
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  cmd_e            pending_cmd_q, pending_cmd_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
`ifdef AXI_ISOLATE_SEQ_TIMEOUT_EN
  // Remembers that the current Releasing pass was caused by a drain timeout,
  // so the error can be reported together with done on reconnection.
  logic            timeout_q, timeout_d;
`endif

  cmd_e cmd;
  logic cmd_fire;

  assign cmd      = cmd_e'(cmd_i);
  assign cmd_fire = cmd_valid_i & cmd_ready_o;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_ISOLATED;
      cnt_q         <= '0;
      pending_cmd_q <= CMD_CONNECT;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef AXI_ISOLATE_SEQ_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_cmd_q <= pending_cmd_d;
      done_q        <= done_d;
      error_q       <= error_d;
`ifdef AXI_ISOLATE_SEQ_TIMEOUT_EN
      timeout_q     <= timeout_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pending_cmd_d = pending_cmd_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
`ifdef AXI_ISOLATE_SEQ_TIMEOUT_EN
    timeout_d     = timeout_q;
`endif

    unique case (state_q)
      ST_CONNECTED: begin
        if (cmd_fire) begin
          unique case (cmd)
            CMD_CONNECT: done_d = 1'b1;
            CMD_ISOLATE, CMD_RESET: begin
              state_d       = ST_DRAINING;
              pending_cmd_d = cmd;
`ifdef AXI_ISOLATE_SEQ_TIMEOUT_EN
              cnt_d         = TimeoutLoad;
`endif
            end
            default: begin
              done_d  = 1'b1;
              error_d = 1'b1;
            end
          endcase
        end
      end

      ST_DRAINING: begin
        // A real isolated indication wins over a watchdog expiring in the
        // same cycle.
        if (isolated_i) begin
          if (pending_cmd_q == CMD_RESET) begin
            state_d = ST_RESET;
            cnt_d   = ResetLoad;
          end else begin
            state_d = ST_ISOLATED;
            done_d  = 1'b1;
          end
        end
`ifdef AXI_ISOLATE_SEQ_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d   = ST_RELEASING;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
`endif
      end

      ST_ISOLATED: begin
        if (cmd_fire) begin
          unique case (cmd)
            CMD_CONNECT: state_d = ST_RELEASING;
            CMD_RESET: begin
              state_d       = ST_RESET;
              pending_cmd_d = CMD_RESET;
              cnt_d         = ResetLoad;
            end
            CMD_ISOLATE: done_d = 1'b1;
            default: begin
              done_d  = 1'b1;
              error_d = 1'b1;
            end
          endcase
        end
      end

      ST_RESET: begin
        if (cnt_q == '0) begin
          if (SettleCycles == 0) begin
            state_d = ST_ISOLATED;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = SettleLoad;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_ISOLATED;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      ST_RELEASING: begin
        if (!isolated_i) begin
          state_d = ST_CONNECTED;
          done_d  = 1'b1;
`ifdef AXI_ISOLATE_SEQ_TIMEOUT_EN
          error_d   = timeout_q;
          timeout_d = 1'b0;
`endif
        end
      end

      default: state_d = ST_ISOLATED;
    endcase
  end

  // Outputs decode from registered state and pulse flops only.
  always_comb begin
    cmd_ready_o   = (state_q == ST_CONNECTED) || (state_q == ST_ISOLATED);
    isolate_o     = !((state_q == ST_CONNECTED) || (state_q == ST_RELEASING));
    domain_rst_no = (state_q != ST_RESET);
    state_o       = state_q;
    done_o        = done_q;
    error_o       = error_q;
  end

endmodule

// File: tb/tb_axi_isolate_seq.sv
module tb_axi_isolate_seq;
  import axi_isolate_seq_pkg::*;

  localparam int R = 8;
  localparam int S = 4;
`ifdef AXI_ISOLATE_SEQ_TIMEOUT_EN
  localparam int T = 16;
`else
  localparam int T = 1024;
`endif
  localparam int BUDGET = 200;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [1:0] cmd_i;
  logic       done_o;
  logic       error_o;
  logic       isolate_o;
  logic       isolated_i;
  logic       domain_rst_no;
  logic [2:0] state_o;

  int vectors     = 0;
  int miscompares = 0;
  int txn_id      = 0;

  typedef struct {
    int         len;
    int         done_idx;
    bit         err_at_done;
    int         err_extra;
    int         iso_high;
    int         rst_low;
    int         rst_first;
    int         rst_last;
    int         ready_mid;
    int         iso_chg;
    logic [2:0] st;
    bit         hung;
  } meas_t;

  axi_isolate_seq #(
    .ResetCycles  (R),
    .SettleCycles (S),
    .TimeoutCycles(T)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_i        (cmd_i),
    .done_o       (done_o),
    .error_o      (error_o),
    .isolate_o    (isolate_o),
    .isolated_i   (isolated_i),
    .domain_rst_no(domain_rst_no),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Issue one command at the current falling edge and follow it to done_o.
  // The isolation stage is emulated here: isolated_i follows isolate_o after
  // 'delay' extra cycles. Returns at the falling edge where done_o is seen.
  task automatic run_cmd(input logic [1:0] c, input int delay, output meas_t m);
    int idx;
    int waitc;
    m = '{default: 0};
    vectors++;
    if (cmd_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_at_issue: got %b want 1 (cmd %0d)", cmd_ready_o, c);
    end
    cmd_valid_i = 1'b1;
    cmd_i       = c;
    idx   = 0;
    waitc = 0;
    forever begin
      @(posedge clk_i);
      @(negedge clk_i);
      idx++;
      if (idx == 1) cmd_valid_i = 1'b0;
      if (isolate_o === 1'b1) m.iso_high++;
      if (domain_rst_no === 1'b0) begin
        m.rst_low++;
        if (m.rst_first == 0) m.rst_first = idx;
        m.rst_last = idx;
      end
      if (error_o === 1'b1 && done_o !== 1'b1) m.err_extra++;
      if (done_o === 1'b1) begin
        m.done_idx    = idx;
        m.err_at_done = error_o;
        m.st          = state_o;
        break;
      end
      if (cmd_ready_o === 1'b1) m.ready_mid++;
      if (idx >= BUDGET) begin
        m.hung = 1'b1;
        break;
      end
      if (isolated_i !== isolate_o) begin
        if (waitc >= delay) begin
          isolated_i = isolate_o;
          m.iso_chg  = idx;
          waitc      = 0;
        end else begin
          waitc++;
        end
      end
    end
    m.len = idx;
    txn_id++;
    $display("txn %0d: cmd=%0d delay=%0d done_at=%0d err=%0b rst_low=%0d state=%0d",
             txn_id, c, delay, m.done_idx, m.err_at_done, m.rst_low, m.st);
    vectors++;
    if (m.hung) begin
      miscompares++;
      $display("FAIL done_timeout: no done_o within %0d cycles (cmd %0d)", BUDGET, c);
    end
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_i       = 2'd0;
    isolated_i  = 1'b1;
    repeat (3) @(negedge clk_i);
    vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", cmd_ready_o); end
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done_o); end
    vectors++; if (error_o !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", error_o); end
    vectors++; if (isolate_o !== 1'b1) begin miscompares++; $display("FAIL reset_isolate: got %b want 1", isolate_o); end
    vectors++; if (domain_rst_no !== 1'b1) begin miscompares++; $display("FAIL reset_domain_rst: got %b want 1", domain_rst_no); end
    vectors++; if (state_o !== ST_ISOLATED) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", state_o, ST_ISOLATED); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    vectors++; if (state_o !== ST_ISOLATED) begin miscompares++; $display("FAIL post_reset_state: got %0d want %0d", state_o, ST_ISOLATED); end
  endtask

  // Isolated -> Connected, stage drops isolated_i one cycle after isolate_o falls.
  task automatic test_connect();
    meas_t m;
    run_cmd(2'd0, 1, m);
    vectors++; if (m.done_idx !== 3) begin miscompares++; $display("FAIL connect_latency: got %0d want 3", m.done_idx); end
    vectors++; if (m.iso_high !== 0) begin miscompares++; $display("FAIL connect_isolate_low: got %0d high cycles want 0", m.iso_high); end
    vectors++; if (m.st !== ST_CONNECTED) begin miscompares++; $display("FAIL connect_state: got %0d want %0d", m.st, ST_CONNECTED); end
    vectors++; if (m.err_at_done !== 1'b0) begin miscompares++; $display("FAIL connect_error: got %b want 0", m.err_at_done); end
    @(negedge clk_i);
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL connect_done_once: got %b want 0", done_o); end
  endtask

  task automatic test_illegal();
    meas_t m;
    run_cmd(2'd3, 0, m);
    vectors++; if (m.done_idx !== 1) begin miscompares++; $display("FAIL illegal_latency: got %0d want 1", m.done_idx); end
    vectors++; if (m.err_at_done !== 1'b1) begin miscompares++; $display("FAIL illegal_error: got %b want 1", m.err_at_done); end
    vectors++; if (m.st !== ST_CONNECTED) begin miscompares++; $display("FAIL illegal_state: got %0d want %0d", m.st, ST_CONNECTED); end
    @(negedge clk_i);
    vectors++; if (error_o !== 1'b0) begin miscompares++; $display("FAIL illegal_error_once: got %b want 0", error_o); end
  endtask

  // Connected -> Isolated with isolated_i held low for 20 cycles.
  task automatic test_isolate();
    meas_t m;
    run_cmd(2'd1, 20, m);
    vectors++; if (m.done_idx !== m.iso_chg + 1 || m.iso_chg !== 21) begin miscompares++; $display("FAIL isolate_latency: got %0d want %0d", m.done_idx, 22); end
    vectors++; if (m.iso_high !== m.len) begin miscompares++; $display("FAIL isolate_held: got %0d high cycles want %0d", m.iso_high, m.len); end
    vectors++; if (m.ready_mid !== 0) begin miscompares++; $display("FAIL isolate_ready_low: got %0d ready cycles want 0", m.ready_mid); end
    vectors++; if (m.st !== ST_ISOLATED) begin miscompares++; $display("FAIL isolate_state: got %0d want %0d", m.st, ST_ISOLATED); end
  endtask

  task automatic test_domain_reset();
    meas_t m;
    run_cmd(2'd2, 0, m);
    vectors++; if (m.rst_low !== R) begin miscompares++; $display("FAIL dreset_low_cycles: got %0d want %0d", m.rst_low, R); end
    vectors++; if (m.rst_first !== 1 || m.rst_last !== R) begin miscompares++; $display("FAIL dreset_window: got %0d..%0d want 1..%0d", m.rst_first, m.rst_last, R); end
    vectors++; if (m.done_idx !== R + S + 1) begin miscompares++; $display("FAIL dreset_settle: got %0d want %0d", m.done_idx, R + S + 1); end
    vectors++; if (m.iso_high !== m.len) begin miscompares++; $display("FAIL dreset_isolate: got %0d high cycles want %0d", m.iso_high, m.len); end
    vectors++; if (m.st !== ST_ISOLATED) begin miscompares++; $display("FAIL dreset_state: got %0d want %0d", m.st, ST_ISOLATED); end
  endtask

  // New commands issued in the very cycle done_o pulses.
  task automatic test_back_to_back();
    meas_t m1, m2;
    run_cmd(2'd0, 0, m1);
    run_cmd(2'd2, 2, m2);
    vectors++; if (m1.st !== ST_CONNECTED) begin miscompares++; $display("FAIL b2b_connect_state: got %0d want %0d", m1.st, ST_CONNECTED); end
    vectors++; if (m2.rst_first !== m2.iso_chg + 1) begin miscompares++; $display("FAIL b2b_drain_to_reset: got %0d want %0d", m2.rst_first, m2.iso_chg + 1); end
    vectors++; if (m2.done_idx !== m2.rst_first + R + S) begin miscompares++; $display("FAIL b2b_reset_done: got %0d want %0d", m2.done_idx, m2.rst_first + R + S); end
    vectors++; if (m2.st !== ST_ISOLATED) begin miscompares++; $display("FAIL b2b_reset_state: got %0d want %0d", m2.st, ST_ISOLATED); end
  endtask

  // Random commands against an abstract model of the port (connected or not).
  task automatic test_random();
    meas_t      m;
    bit         conn;
    bit         nconn;
    logic [1:0] c;
    int         d;
    int         edone;
    int         efirst;
    conn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      c = 2'($urandom_range(0, 3));
      d = $urandom_range(0, 5);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      run_cmd(c, d, m);
      nconn  = conn;
      edone  = 1;
      efirst = 0;
      case (c)
        2'd0: begin nconn = 1'b1; if (!conn) edone = m.iso_chg + 1; end
        2'd1: begin nconn = 1'b0; if (conn) edone = m.iso_chg + 1; end
        2'd2: begin
          nconn  = 1'b0;
          efirst = conn ? m.iso_chg + 1 : 1;
          edone  = efirst + R + S;
        end
        default: ;
      endcase
      vectors++; if (m.done_idx !== edone) begin miscompares++; $display("FAIL rnd%0d_done: got %0d want %0d", i, m.done_idx, edone); end
      vectors++; if (m.err_at_done !== (c == 2'd3)) begin miscompares++; $display("FAIL rnd%0d_error: got %b want %b", i, m.err_at_done, c == 2'd3); end
      vectors++; if (m.err_extra !== 0) begin miscompares++; $display("FAIL rnd%0d_error_alone: got %0d want 0", i, m.err_extra); end
      vectors++; if (m.rst_low !== ((c == 2'd2) ? R : 0)) begin miscompares++; $display("FAIL rnd%0d_rst_low: got %0d want %0d", i, m.rst_low, (c == 2'd2) ? R : 0); end
      if (c == 2'd2) begin
        vectors++; if (m.rst_first !== efirst || m.rst_last !== efirst + R - 1) begin miscompares++; $display("FAIL rnd%0d_rst_window: got %0d..%0d want %0d..%0d", i, m.rst_first, m.rst_last, efirst, efirst + R - 1); end
      end
      vectors++; if (m.iso_high !== (nconn ? 0 : m.len)) begin miscompares++; $display("FAIL rnd%0d_isolate: got %0d want %0d", i, m.iso_high, nconn ? 0 : m.len); end
      vectors++; if (m.ready_mid !== 0) begin miscompares++; $display("FAIL rnd%0d_ready: got %0d want 0", i, m.ready_mid); end
      vectors++; if (m.st !== (nconn ? ST_CONNECTED : ST_ISOLATED)) begin miscompares++; $display("FAIL rnd%0d_state: got %0d want %0d", i, m.st, nconn ? ST_CONNECTED : ST_ISOLATED); end
      conn = nconn;
    end
  endtask

`ifdef AXI_ISOLATE_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    meas_t m;
    run_cmd(2'd0, 0, m);
    run_cmd(2'd1, 100000, m);
    vectors++; if (m.done_idx !== T + 2) begin miscompares++; $display("FAIL timeout_latency: got %0d want %0d", m.done_idx, T + 2); end
    vectors++; if (m.err_at_done !== 1'b1) begin miscompares++; $display("FAIL timeout_error: got %b want 1", m.err_at_done); end
    vectors++; if (m.iso_high !== T) begin miscompares++; $display("FAIL timeout_drain_cycles: got %0d want %0d", m.iso_high, T); end
    vectors++; if (m.st !== ST_CONNECTED) begin miscompares++; $display("FAIL timeout_state: got %0d want %0d", m.st, ST_CONNECTED); end
    vectors++; if (m.rst_low !== 0) begin miscompares++; $display("FAIL timeout_no_reset: got %0d want 0", m.rst_low); end
  endtask
`endif

  task automatic test_async_reset();
    int n;
    cmd_valid_i = 1'b1;
    cmd_i       = 2'd2;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    n = 0;
    while (domain_rst_no !== 1'b0 && n < 100) begin
      isolated_i = isolate_o;
      @(posedge clk_i);
      @(negedge clk_i);
      n++;
    end
    vectors++; if (domain_rst_no !== 1'b0) begin miscompares++; $display("FAIL async_enter_reset: got %b want 0", domain_rst_no); end
    @(posedge clk_i);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    vectors++; if (domain_rst_no !== 1'b1) begin miscompares++; $display("FAIL async_domain_rst: got %b want 1", domain_rst_no); end
    vectors++; if (isolate_o !== 1'b1) begin miscompares++; $display("FAIL async_isolate: got %b want 1", isolate_o); end
    vectors++; if (state_o !== ST_ISOLATED) begin miscompares++; $display("FAIL async_state: got %0d want %0d", state_o, ST_ISOLATED); end
    vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL async_ready: got %b want 1", cmd_ready_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    vectors++; if (state_o !== ST_ISOLATED || done_o !== 1'b0) begin miscompares++; $display("FAIL async_release: got state %0d done %b want %0d 0", state_o, done_o, ST_ISOLATED); end
  endtask

  initial begin
    test_reset();
    test_connect();
    test_illegal();
    test_isolate();
    test_domain_reset();
    test_back_to_back();
    test_random();
`ifdef AXI_ISOLATE_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_isolate_seq.md
# axi_isolate_seq

Sequencer that drives the `isolate`/`isolated` handshake of one AXI isolation stage and the reset of the downstream subsystem behind it. It accepts software-level commands (connect, isolate, reset domain) over a valid/ready port and runs the multi-cycle sequence for each: drain, isolate, pulse reset, settle, reconnect. It sits next to the isolation stage in the SoC interconnect, typically driven by a control register block.

## Interface
- `ResetCycles`, default 8: cycles `domain_rst_no` is held low; must be ≥1.
- `SettleCycles`, default 4: cycles waited after reset release before reporting done; 0 skips Settle.
- `TimeoutCycles`, default 1024: drain watchdog limit; used only with the timeout macro; must be ≥1.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command accepted when valid && ready.
- `cmd_i`  in  2  `cmd_e`: 0 Connect, 1 Isolate, 2 Reset, 3 illegal.
- `done_o`  out  1  one-cycle pulse on command completion.
- `error_o`  out  1  one-cycle pulse, coincident with `done_o`, for an illegal command or timeout.
- `isolate_o`  out  1  to the isolation stage's isolate request.
- `isolated_i`  in  1  from the isolation stage's isolated status.
- `domain_rst_no`  out  1  active-low reset to the downstream domain.
- `state_o`  out  3  current `state_e`, for status registers.

## Operation
- States: Connected, Draining, Isolated, Reset, Settle, Releasing. Reset state is Isolated, which matches the isolation stage's own reset state.
- `cmd_ready_o` = 1 only in Connected and Isolated. All other states ignore `cmd_valid_i`.
- Connected:
  - Isolate or Reset → Draining.
  - Connect → stay; pulse `done_o` next cycle.
  - Illegal → stay; pulse `done_o` and `error_o`.
- Draining: `isolate_o` = 1. When `isolated_i` is sampled 1:
  - for an Isolate command → Isolated, pulse done;
  - for a Reset command → Reset.
  - A 2-bit `pending_cmd_q` latches the accepted command.
- Isolated:
  - Connect → Releasing.
  - Reset → Reset.
  - Isolate → stay; pulse done.
  - Illegal → error and done pulse.
- Reset: `domain_rst_no` = 0 and `isolate_o` = 1 for exactly ResetCycles cycles, then → Settle. If SettleCycles = 0, go directly → Isolated with done.
- Settle: `isolate_o` = 1 for SettleCycles cycles → Isolated; pulse done. A completed Reset command always leaves the port isolated.
- Releasing: `isolate_o` = 0. When `isolated_i` is sampled 0 → Connected; pulse done.
- One shared down-counter serves Reset, Settle and the watchdog.
  - Width: `$clog2(max(ResetCycles, SettleCycles, TimeoutCycles)+1)`.
  - Loaded with N-1 on state entry; the state exits when the counter equals 0 in that state.

## Timing
- All outputs are registered, derived from `state_q` and pulse flops; there is no combinational path from input to output except `cmd_ready_o`, which decodes from `state_q` only.
- Reset values: `cmd_ready_o`=1, `done_o`=0, `error_o`=0, `isolate_o`=1, `domain_rst_no`=1, `state_o`=Isolated.
- Latencies:
  - `isolate_o` rises in the cycle after the command handshake.
  - The Draining exit occurs in the cycle after `isolated_i`=1 is sampled.
  - `done_o` is high in the first cycle of the destination stable state, and `cmd_ready_o` is already 1 in that cycle.
  - A new command may be accepted in the same cycle `done_o` pulses.
  - No-op or illegal commands: `done_o` is high in the cycle after the handshake.
- Reset sequence from Connected: 1 cycle handshake → Draining (≥1 cycle) → ResetCycles → SettleCycles → Isolated.
- Asynchronous reset mid-sequence aborts immediately to the reset values. `domain_rst_no` returns to 1 at once.

## Configuration
- `AXI_ISOLATE_SEQ_TIMEOUT_EN` defined: in Draining, the counter is loaded with TimeoutCycles-1. On expiry:
  - pulse `error_o`, → Releasing (`isolate_o` = 0), then → Connected with `done_o`;
  - the Reset is not performed;
  - the isolation stage finishes its own drain and reconnects.
- Undefined: Draining waits indefinitely for `isolated_i`, and TimeoutCycles is unused.

## Structure
- Package `axi_isolate_seq_pkg`: `cmd_e` (2-bit), `state_e` (3-bit), and the encodings for `state_o`.
- Single module with no sub-module. The shared counter and state machine are inline; `FFARN`-style flops are used for state, counter, pending command and pulses.

## Test plan
- Reset, then Connect with `isolated_i` dropping 1 cycle after `isolate_o`=0 → Connected; `done_o` pulses exactly once; `state_o`=Connected.
- Isolate in Connected, `isolated_i` held low 20 cycles then high → `isolate_o`=1 throughout, `done_o` 1 cycle after `isolated_i` rises, `cmd_ready_o`=0 while draining.
- Reset from Isolated with ResetCycles=8, SettleCycles=4 → `domain_rst_no` low exactly 8 cycles, `done_o` 4 cycles after release, `isolate_o` stays 1.
- `cmd_i`=3 in Connected → `done_o` and `error_o` pulse together next cycle; state unchanged.
- With the macro and TimeoutCycles=16, Isolate with `isolated_i` stuck 0 → `error_o`+`done_o` after 16 Draining cycles, `isolate_o` back to 0, state Connected.
- Assert `rst_ni` low during Reset state → `domain_rst_no`=1, `isolate_o`=1, `state_o`=Isolated immediately (asynchronous).
